cga_sequencer: RTL and testbench

//  Master timing sequencer for the CGA pixel path. It runs off the pixel master clock
//  and produces the 5-bit clk_seq phase, CRTC character clock and VRAM fetch strobes.
//  It also generates the char-ROM load and display-pipeline strobes consumed by cga_pixel.
//  It arbitrates one CPU (ISA) VRAM slot per character period by req/ack handshake.

---
 rtl/cga_sequencer_if.sv | 27 ++
 rtl/cga_sequencer.sv | 94 +++++++++
 tb/tb_cga_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cga_sequencer_if.sv
// Bundle of the CGA sequencer's control inputs and timing/strobe outputs.
// The master drives mode and CPU request; the slave (sequencer) drives everything else.
interface cga_sequencer_if;
  logic       hres_mode;
  logic       isa_req;
  logic [4:0] clk_seq;
  logic       crtc_clk;
  logic       vram_read;
  logic       vram_read_char;
  logic       vram_read_att;
  logic       charrom_read;
  logic       disp_pipeline;
  logic       isa_op_enable;
  logic       isa_ack;

  modport master (
    output hres_mode, isa_req,
    input  clk_seq, crtc_clk, vram_read, vram_read_char, vram_read_att,
           charrom_read, disp_pipeline, isa_op_enable, isa_ack
  );

  modport slave (
    input  hres_mode, isa_req,
    output clk_seq, crtc_clk, vram_read, vram_read_char, vram_read_att,
           charrom_read, disp_pipeline, isa_op_enable, isa_ack
  );
endinterface

// File: rtl/cga_sequencer.sv
// CGA master timing sequencer: 32-phase counter, character-rate strobes and
// one CPU VRAM slot per character. All outputs decode the next phase and are registered.
module cga_sequencer #(
  parameter int CPU_WIN_START = 9,
  parameter int CPU_WIN_END   = 14
) (
  input  logic            clk,
  input  logic            reset,
  cga_sequencer_if.slave  bus
);
  localparam logic [3:0] WIN_LO = 4'(CPU_WIN_START);
  localparam logic [3:0] WIN_HI = 4'(CPU_WIN_END);

  logic [4:0] seq_q, seq_d;
  logic       hres_q, hres_d;
  logic [3:0] phase_s;
  logic       pulse_en_s, first_clk_s;
  logic       crtc_q, crtc_d;
  logic       vram_rd_q, vram_rd_d;
  logic       rd_char_q, rd_char_d;
  logic       rd_att_q, rd_att_d;
  logic       rom_q, rom_d;
  logic       disp_q, disp_d;
  logic       win_q, win_d;
  logic       ack_q, ack_d;

  // Next-phase decode: strobes are computed for the phase the counter is about to show.
  always_comb begin
    seq_d = seq_q + 5'd1;
    if (seq_q == 5'd31) begin
      hres_d = bus.hres_mode;
    end else begin
      hres_d = hres_q;
    end
    if (hres_d) begin
      phase_s     = seq_d[3:0];
      pulse_en_s  = 1'b1;
      first_clk_s = 1'b1;
    end else begin
      phase_s     = seq_d[4:1];
      pulse_en_s  = seq_d[0];
      first_clk_s = ~seq_d[0];
    end
    crtc_d    = pulse_en_s & (phase_s == 4'd0);
    rd_char_d = pulse_en_s & (phase_s == 4'd3);
    rd_att_d  = pulse_en_s & (phase_s == 4'd7);
    rom_d     = pulse_en_s & (phase_s == 4'd8);
    disp_d    = pulse_en_s & (phase_s == 4'd15);
    case (phase_s)
      4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7: vram_rd_d = 1'b1;
      default:                            vram_rd_d = 1'b0;
    endcase
    // Display fetch always wins the bus if the CPU window is configured to overlap it.
    win_d = (phase_s >= WIN_LO) & (phase_s <= WIN_HI) & ~vram_rd_d;
    ack_d = win_d & first_clk_s & (phase_s == WIN_LO) & bus.isa_req;
  end

  // Sequence state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q     <= 5'd0;
      hres_q    <= 1'b0;
      crtc_q    <= 1'b0;
      vram_rd_q <= 1'b0;
      rd_char_q <= 1'b0;
      rd_att_q  <= 1'b0;
      rom_q     <= 1'b0;
      disp_q    <= 1'b0;
      win_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      hres_q    <= hres_d;
      crtc_q    <= crtc_d;
      vram_rd_q <= vram_rd_d;
      rd_char_q <= rd_char_d;
      rd_att_q  <= rd_att_d;
      rom_q     <= rom_d;
      disp_q    <= disp_d;
      win_q     <= win_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.clk_seq        = seq_q;
  assign bus.crtc_clk       = crtc_q;
  assign bus.vram_read      = vram_rd_q;
  assign bus.vram_read_char = rd_char_q;
  assign bus.vram_read_att  = rd_att_q;
  assign bus.charrom_read   = rom_q;
  assign bus.disp_pipeline  = disp_q;
  assign bus.isa_op_enable  = win_q;
  assign bus.isa_ack        = ack_q;
endmodule

// File: tb/tb_cga_sequencer.sv
// Randomized scoreboard bench for cga_sequencer: a cycle-level reference model
// pushes expected output vectors; a negedge monitor pops and compares them.
module tb_cga_sequencer;
  logic clk = 1'b0;
  logic reset;
  cga_sequencer_if bus();

  cga_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [12:0] exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  bit  done       = 1'b0;

  int  m_seq;
  bit  m_hres;
  logic [12:0] m_out;
  bit  prev_reset, prev_hres, prev_req;

  // Expected outputs while clk_seq shows seq; req_before is the request held up to that cycle.
  function automatic logic [12:0] model_outputs(int seq, bit hres, bit req_before);
    int p;
    bit fire, first, crtc, vr, ch, att, rom, disp, win, ack;
    p     = hres ? (seq % 16) : (seq / 2);
    fire  = hres || (seq % 2 == 1);
    first = hres || (seq % 2 == 0);
    crtc  = fire && (p == 0);
    ch    = fire && (p == 3);
    att   = fire && (p == 7);
    rom   = fire && (p == 8);
    disp  = fire && (p == 15);
    vr    = p inside {1, 2, 3, 5, 6, 7};
    win   = (p >= 9) && (p <= 14);
    ack   = req_before && first && (p == 9);
    return {5'(seq), crtc, vr, ch, att, rom, disp, win, ack};
  endfunction

  task automatic step(input bit rst, input bit hres, input bit req);
    @(posedge clk);
    #2;
    if (prev_reset) begin
      m_seq = 0; m_hres = 1'b0; m_out = 13'd0;
    end else begin
      if (m_seq == 31) m_hres = prev_hres;
      m_seq = (m_seq + 1) % 32;
      m_out = model_outputs(m_seq, m_hres, prev_req);
    end
    reset         = rst;
    bus.hres_mode = hres;
    bus.isa_req   = req;
    if (rst) begin
      m_seq = 0; m_hres = 1'b0; m_out = 13'd0;
    end
    exp_q.push_back(m_out);
    prev_reset = rst;
    prev_hres  = hres;
    prev_req   = req;
  endtask

  // Monitor: compare every presented output vector against the scoreboard.
  initial begin
    logic [12:0] act, expv;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act  = {bus.clk_seq, bus.crtc_clk, bus.vram_read, bus.vram_read_char,
                bus.vram_read_att, bus.charrom_read, bus.disp_pipeline,
                bus.isa_op_enable, bus.isa_ack};
        compared++;
        if (act !== expv) begin
          mismatched++;
          $display("FAIL outputs t=%0t actual=%b required=%b (seq,crtc,vr,chr,att,rom,disp,win,ack)",
                   $time, act, expv);
        end
        compared++;
        if ((bus.vram_read & bus.isa_op_enable) !== 1'b0) begin
          mismatched++;
          $display("FAIL overlap t=%0t actual vram_read&isa_op_enable=%b required=0",
                   $time, bus.vram_read & bus.isa_op_enable);
        end
      end
    end
  end

  initial begin
    bit hres, req;
    reset = 1'b1; bus.hres_mode = 1'b0; bus.isa_req = 1'b0;
    m_seq = 0; m_hres = 1'b0; m_out = 13'd0;
    prev_reset = 1'b1; prev_hres = 1'b0; prev_req = 1'b0;

    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (70) step(1'b0, 1'b1, 1'b0);          // hres timing
    repeat (64) step(1'b0, 1'b1, 1'b1);          // hres, request held
    repeat (70) step(1'b0, 1'b0, 1'b0);          // back to lowres
    repeat (64) step(1'b0, 1'b0, 1'b1);          // lowres, request held
    for (int i = 0; i < 40 && m_seq != 9; i++) step(1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);          // mode change mid-sequence
    for (int i = 0; i < 40 && m_seq != 10; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);                      // request rises mid-window
    for (int i = 0; i < 40 && !bus.isa_ack; i++) step(1'b0, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_seq != 11; i++) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1);           // reset mid-sequence with request pending
    repeat (40) step(1'b0, 1'b1, 1'b1);

    hres = 1'b1; req = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) hres = ~hres;
      if ($urandom_range(0, 5) == 0) req = ~req;
      step(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0, hres, req);
    end

    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain actual pending=%0d required=0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
